// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU program sequencer.
// Optional divide-by-zero check in alu_sequencer is enabled by ALU_SEQ_DIVZ_CHECK_EN.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec
  } state_e;

  // Instruction field positions within the 16-bit word
  localparam int unsigned OpMsb  = 15;
  localparam int unsigned OpLsb  = 12;
  localparam int unsigned RdMsb  = 11;
  localparam int unsigned RdLsb  = 10;
  localparam int unsigned RsMsb  = 9;
  localparam int unsigned RsLsb  = 8;
  localparam int unsigned ImmMsb = 7;
  localparam int unsigned ImmLsb = 0;

  localparam logic [3:0] OpHalt = 4'hF;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluMul  = 4'd2;
  localparam logic [3:0] AluDiv  = 4'd3;
  localparam logic [3:0] AluMod  = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluNor  = 4'd6;
  localparam logic [3:0] AluXnor = 4'd7;

endpackage

// File: rtl/alu_seq_regfile.sv
// 4-entry register file: one write port, three combinational read ports, sync clear.
module alu_seq_regfile #(
  parameter int unsigned BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [1:0]      waddr,
  input  logic [BITS-1:0] wdata,
  input  logic [1:0]      raddr_a,
  output logic [BITS-1:0] rdata_a,
  input  logic [1:0]      raddr_b,
  output logic [BITS-1:0] rdata_b,
  input  logic [1:0]      raddr_dbg,
  output logic [BITS-1:0] rdata_dbg
);

  logic [BITS-1:0] regs_q [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a   = regs_q[raddr_a];
  assign rdata_b   = regs_q[raddr_b];
  assign rdata_dbg = regs_q[raddr_dbg];

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/exec sequencer driving a combinational ALU from a registered instruction ROM.
// Define ALU_SEQ_DIVZ_CHECK_EN to abort runs on divide/modulo by zero and flag err.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned BITS = 8,
  parameter int unsigned OP   = 4,
  parameter int unsigned SIZE = 4,
  parameter int unsigned IW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            rom_en,
  output logic [SIZE-1:0] rom_addr,
  input  logic [IW-1:0]   rom_data,
  output logic            alu_en,
  output logic [OP-1:0]   alu_op,
  output logic [BITS-1:0] alu_a,
  output logic [BITS-1:0] alu_b,
  input  logic [BITS-1:0] alu_result,
  output logic            busy,
  output logic            done,
  output logic            err,
  input  logic [1:0]      rf_raddr,
  output logic [BITS-1:0] rf_rdata
);

  state_e          state_q;
  logic [SIZE-1:0] pc_q;
  logic            rom_en_q, busy_q, done_q, err_q;

  logic [3:0]      op_f;
  logic [1:0]      rd_f, rs_f;
  logic [7:0]      imm_f;
  logic [BITS-1:0] rs_data, rs2_data;
  logic            in_exec, is_halt, divz, rf_we;

  assign op_f  = rom_data[OpMsb:OpLsb];
  assign rd_f  = rom_data[RdMsb:RdLsb];
  assign rs_f  = rom_data[RsMsb:RsLsb];
  assign imm_f = rom_data[ImmMsb:ImmLsb];

  assign in_exec = (state_q == StExec);
  assign is_halt = (op_f == OpHalt);

  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (in_exec && !is_halt) begin
      alu_a = rs_data;
      if (op_f[3]) begin
        alu_op = OP'(op_f[2:0]);
        alu_b  = BITS'(imm_f);
      end else begin
        alu_op = OP'(op_f);
        alu_b  = rs2_data;
      end
    end
  end

`ifdef ALU_SEQ_DIVZ_CHECK_EN
  assign divz = in_exec && !is_halt && (alu_b == '0) &&
                ((alu_op == OP'(AluDiv)) || (alu_op == OP'(AluMod)));
`else
  assign divz = 1'b0;
`endif

  assign rf_we = in_exec && !is_halt && !divz;

  alu_seq_regfile #(
    .BITS(BITS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (rd_f),
    .wdata    (alu_result),
    .raddr_a  (rs_f),
    .rdata_a  (rs_data),
    .raddr_b  (imm_f[1:0]),
    .rdata_b  (rs2_data),
    .raddr_dbg(rf_raddr),
    .rdata_dbg(rf_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      rom_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StFetch;
            pc_q     <= '0;
            err_q    <= 1'b0;
            rom_en_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        StFetch: begin
          state_q  <= StExec;
          rom_en_q <= 1'b0;
        end
        StExec: begin
          if (is_halt || divz) begin
            // PC stays on the terminating word
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= divz;
          end else begin
            pc_q <= pc_q + 1'b1;
            if (pc_q == '1) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q  <= StFetch;
              rom_en_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          rom_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rom_en   = rom_en_q;
  assign rom_addr = pc_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign alu_en   = ~reset;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a registered ROM and ALU model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        rom_en;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic        alu_en;
  logic [3:0]  alu_op;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic        busy, done, err;
  logic [1:0]  rf_raddr;
  logic [7:0]  rf_rdata;

  logic [15:0] rom [16];
  int          passed = 0;
  int          total  = 0;
  int          cyc    = 0;

  always #5 clk = ~clk;

  alu_sequencer #(
    .BITS(8),
    .OP  (4),
    .SIZE(4),
    .IW  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .alu_en    (alu_en),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_result(alu_result),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata)
  );

  always @(posedge clk) begin
    if (rom_en) rom_data <= rom[rom_addr];
  end

  always_comb begin
    case (alu_op)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a * alu_b;
      4'd3:    alu_result = (alu_b == 8'd0) ? 8'hFF : alu_a / alu_b;
      4'd4:    alu_result = (alu_b == 8'd0) ? 8'hFF : alu_a % alu_b;
      4'd5:    alu_result = alu_a ^ alu_b;
      4'd6:    alu_result = ~(alu_a | alu_b);
      4'd7:    alu_result = ~(alu_a ^ alu_b);
      default: alu_result = 8'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reg(input logic [1:0] idx, input logic [7:0] exp, input string tag);
    rf_raddr = idx;
    #1;
    check(tag, rf_rdata, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Leaves the bench at the negedge just after the start-sampling edge, cyc = 0
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_done(input string tag);
    while (done !== 1'b1 && cyc < 200) tick();
    check(tag, done, 1'b1);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rf_raddr = 2'd0;
    for (int i = 0; i < 16; i++) rom[i] = 16'hF000;
    tick();
    tick();
    check("rst_rom_en", rom_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rom_addr", rom_addr, 4'd0);
    check("rst_alu_en", alu_en, 1'b0);
    check("rst_alu_op", alu_op, 4'd0);
    check("rst_alu_ab", {alu_a, alu_b}, 16'd0);
    for (int i = 0; i < 4; i++) chk_reg(2'(i), 8'd0, "rst_reg");
    reset = 1'b0;
    tick();
    check("alu_en_run", alu_en, 1'b1);

    // Immediate add then register multiply, halt at 2
    rom[0] = 16'h8005;
    rom[1] = 16'h2400;
    rom[2] = 16'hF000;
    pulse_start();
    check("t1_busy", busy, 1'b1);
    check("t1_rom_en", rom_en, 1'b1);
    tick();
    check("t1_exec_op", alu_op, 4'd0);
    check("t1_exec_ab", {alu_a, alu_b}, {8'd0, 8'd5});
    tick();
    check("t1_idle_ab", {alu_op, alu_a, alu_b}, 20'd0);
    wait_done("t1_done_seen");
    check("t1_done_cycle", cyc, 6);
    check("t1_busy_low", busy, 1'b0);
    check("t1_pc", rom_addr, 4'd2);
    check("t1_err", err, 1'b0);
    chk_reg(2'd0, 8'd5, "t1_r0");
    chk_reg(2'd1, 8'd25, "t1_r1");
    tick();
    check("t1_done_pulse", done, 1'b0);

    // Add overflow truncates to 8 bits
    do_reset();
    rom[0] = 16'h80FF;
    rom[1] = 16'h8001;
    rom[2] = 16'hF000;
    pulse_start();
    wait_done("t2_done_seen");
    check("t2_done_cycle", cyc, 6);
    chk_reg(2'd0, 8'h00, "t2_r0");

    // Register-form divide by R2 = 0
    do_reset();
    rom[0] = 16'h3802;
    rom[1] = 16'hF000;
    pulse_start();
    wait_done("t3_done_seen");
`ifdef ALU_SEQ_DIVZ_CHECK_EN
    check("t3_done_cycle", cyc, 2);
    check("t3_err", err, 1'b1);
    check("t3_pc", rom_addr, 4'd0);
    chk_reg(2'd2, 8'h00, "t3_r2");
`else
    check("t3_done_cycle", cyc, 4);
    check("t3_err", err, 1'b0);
    check("t3_pc", rom_addr, 4'd1);
    chk_reg(2'd2, 8'hFF, "t3_r2");
`endif

    // 16 increments, no HALT: PC wraps and run ends
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 16'h8001;
    pulse_start();
    wait_done("t4_done_seen");
    check("t4_done_cycle", cyc, 32);
    check("t4_busy", busy, 1'b0);
    check("t4_pc", rom_addr, 4'd0);
    chk_reg(2'd0, 8'd16, "t4_r0");

    // Reset during EXEC of the second instruction
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 16'hF000;
    rom[0] = 16'h8005;
    rom[1] = 16'h8403;
    pulse_start();
    tick();
    tick();
    tick();
    check("t5_exec_ab", {alu_a, alu_b}, {8'd5, 8'd3});
    chk_reg(2'd0, 8'd5, "t5_r0_before");
    reset = 1'b1;
    tick();
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    check("t5_rom_en", rom_en, 1'b0);
    check("t5_pc", rom_addr, 4'd0);
    chk_reg(2'd0, 8'd0, "t5_r0");
    chk_reg(2'd1, 8'd0, "t5_r1");
    reset = 1'b0;
    tick();
    tick();
    check("t5_no_done", done, 1'b0);

    // Start re-pulsed mid-run is ignored
    rom[0] = 16'h8005;
    rom[1] = 16'h2400;
    rom[2] = 16'hF000;
    pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t6_done_seen");
    check("t6_done_cycle", cyc, 6);
    chk_reg(2'd0, 8'd5, "t6_r0");
    chk_reg(2'd1, 8'd25, "t6_r1");
    tick();
    tick();
    check("t6_stays_idle", {busy, done}, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Program sequencer that sits directly upstream of the combinational ALU and drives it from the instruction ROM. On a start pulse it fetches instruction words from the registered ROM, decodes them into an ALU opcode and two operands taken from a small internal register file or an immediate, and writes the ALU result back. It runs until a HALT word, program-counter wrap-around, or (optionally) a divide-by-zero, then pulses `done`.

## Interface
- `BITS`, 8: data width of the ALU operands, results and registers.
- `OP`, 4: ALU opcode width.
- `SIZE`, 4: ROM address width; the program holds 2^SIZE words.
- `IW`, 16: instruction word width; fixed at 16, and the encoding below depends on it.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to run the program from address 0.
- `rom_en` out 1: ROM read enable.
- `rom_addr` out SIZE: ROM address (the PC).
- `rom_data` in IW: ROM read data, valid the cycle after `rom_en`.
- `alu_en` out 1: drives the ALU's active-low reset input; 1 means the ALU is enabled.
- `alu_op` out OP: ALU opcode.
- `alu_a` out BITS: ALU operand 1.
- `alu_b` out BITS: ALU operand 2.
- `alu_result` in BITS: combinational ALU result.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse when the run ends.
- `err` out 1: sticky divide-by-zero flag; cleared by `start` or `reset`.
- `rf_raddr` in 2: debug register read address.
- `rf_rdata` out BITS: combinational read of register `rf_raddr`.

## Operation
Instruction encoding:
- `[15:12]` op.
- `[11:10]` rd.
- `[9:8]` rs.
- `[7:0]` imm.

Opcode classes:
- op 0–7, register form: ALU op = op; a = R[rs]; b = R[imm[1:0]].
- op 8–14, immediate form: ALU op = op[2:0]; a = R[rs]; b = imm zero-extended/truncated to BITS.
- op 15: HALT.

State machine:
- IDLE: `start` moves to FETCH, clears PC and `err`. Register contents are kept.
- FETCH: `rom_en`=1, `rom_addr`=PC. Always moves to EXEC.
- EXEC: decodes `rom_data` combinationally.
  - HALT: back to IDLE with `done`; PC holds the HALT address.
  - Otherwise: drive the ALU, write `alu_result` into R[rd] at the cycle's edge, PC+1, then FETCH.
  - If PC was 2^SIZE−1: PC wraps to 0, go to IDLE with `done` (no error).

Rules:
- Results are truncated to BITS (mul/add overflow discarded); sub wraps modulo 2^BITS.
- `start` is ignored while `busy`.
- `reset` mid-run: state IDLE, PC 0, all R cleared, outputs to reset values on the next cycle; in-flight write is dropped.
- Outside EXEC, `alu_op`, `alu_a` and `alu_b` are driven to 0.
- `rom_addr` always shows the PC.

## Timing
- Reset values:
  - `rom_en`, `busy`, `done`, `err` = 0.
  - `rom_addr` = 0.
  - `alu_en` = 0 while `reset` is high, 1 otherwise.
  - `alu_*` = 0.
  - All registers = 0.
- Two cycles per instruction (FETCH, EXEC).
- `start` is sampled at edge E0. Instruction k is written at edge E0+2k+2.
- A HALT at address n gives `done`=1 in the cycle after edge E0+2n+2. `busy` falls on the same edge.
- `done` and `err` are registered outputs.
- The write-back value is visible on `rf_rdata` the cycle after the write.

## Configuration
- `ALU_SEQ_DIVZ_CHECK_EN` defined:
  - In EXEC, ALU op 3 or 4 with b=0 suppresses the write.
  - Sets `err`=1 and goes to IDLE with `done`.
- Undefined:
  - No check; whatever the ALU returns is written; `err` stays 0.

## Structure
- Package `alu_seq_pkg`:
  - State enum (IDLE, FETCH, EXEC).
  - Instruction field positions.
  - HALT opcode constant.
  - ALU opcode constants 0–7 (ADD, SUB, MUL, DIV, MOD, XOR, NOR, XNOR).
- Sub-module `alu_seq_regfile`:
  - 4×BITS registers.
  - One write port and three combinational read ports (rs, rs2, debug).
  - Synchronous clear on reset.

## Test plan
- ROM {0x8005, 0x2400, 0xF000}, `start` → R0=5, R1=25, `done` pulse one cycle after the 6th edge post-start, PC=2, `err`=0.
- ROM {0x80FF, 0x8001, 0xF000} with BITS=8 → 255+1 truncates, R0=0x00.
- With the macro defined, ROM {0x3802, 0xF000} (R2=0) → R2 unchanged, `err`=1, `done` at PC 0. Without the macro → write occurs, `err`=0.
- 16 non-HALT words (SIZE=4) → PC wraps to 0, `done` after 32 cycles, `busy`=0.
- `reset` asserted during the EXEC of the second instruction → next cycle IDLE, all registers 0, `busy`=0, no `done`.
- `start` re-pulsed while `busy` → ignored, run completes with identical results.
